// File: rtl/hr_beat_detect.sv
// Heart-rate extractor: DC removal, 4-tap smoothing, adaptive-threshold peak FSM and
// a sequential 60*Fs/interval divider. Define HR_AVG4_EN to divide by the mean of the last 4 intervals.
module hr_beat_detect #(
    parameter int SAMPLE_RATE  = 100,
    parameter int MIN_INTERVAL = 30,
    parameter int MAX_INTERVAL = 200,
    parameter int FINGER_TH    = 50000,
    parameter int MIN_THR      = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [17:0]        ir_data,
    input  logic               data_valid,
    output logic               finger_on,
    output logic               beat,
    output logic [7:0]         bpm,
    output logic               bpm_valid,
    output logic signed [18:0] ac_out
);
    localparam logic [12:0]        NUMER    = 13'(60 * SAMPLE_RATE);
    localparam logic [7:0]         ICNT_SAT = 8'(MAX_INTERVAL + 1);
    localparam logic signed [18:0] THR_MIN  = 19'(MIN_THR);

    typedef enum logic [1:0] {S_NOF, S_ARM, S_RISE, S_FALL} state_t;

    // Stage 1: DC tracker and AC extraction
    logic [21:0]        dc_acc_q, dc_acc_d;
    logic signed [18:0] ac_q, ac_d;
    logic               fing_q, fing_d, v1_q, v1_d;
    logic               ir_hi;

    assign ir_hi = (ir_data >= 18'(FINGER_TH));

    always_comb begin
        dc_acc_d = dc_acc_q;
        ac_d     = ac_q;
        fing_d   = fing_q;
        v1_d     = data_valid;
        if (data_valid) begin
            fing_d = ir_hi;
            if (!ir_hi || !fing_q) begin
                // Seed the tracker on finger arrival so the AC path starts at zero.
                dc_acc_d = ir_hi ? {ir_data, 4'b0} : dc_acc_q;
                ac_d     = '0;
            end else begin
                dc_acc_d = dc_acc_q + {4'b0, ir_data} - {4'b0, dc_acc_q[21:4]};
                ac_d     = $signed({1'b0, dc_acc_q[21:4]}) - $signed({1'b0, ir_data});
            end
        end
    end

    // Stage 2: 4-tap moving average
    logic signed [18:0] t1_q, t2_q, t3_q, filt_q;
    logic signed [18:0] t1_d, t2_d, t3_d, filt_d;
    logic signed [20:0] sum4;
    logic               v2_q, v2_d, fing2_q, fing2_d;

    always_comb begin
        sum4 = {{2{ac_q[18]}}, ac_q} + {{2{t1_q[18]}}, t1_q}
             + {{2{t2_q[18]}}, t2_q} + {{2{t3_q[18]}}, t3_q};
        t1_d = t1_q; t2_d = t2_q; t3_d = t3_q; filt_d = filt_q;
        v2_d    = v1_q;
        fing2_d = fing2_q;
        if (v1_q) begin
            fing2_d = fing_q;
            if (fing_q) begin
                t1_d = ac_q; t2_d = t1_q; t3_d = t2_q;
                filt_d = sum4[20:2];
            end else begin
                t1_d = '0; t2_d = '0; t3_d = '0; filt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_acc_q <= '0; ac_q <= '0; fing_q <= 1'b0; v1_q <= 1'b0;
            t1_q <= '0; t2_q <= '0; t3_q <= '0; filt_q <= '0;
            v2_q <= 1'b0; fing2_q <= 1'b0;
        end else begin
            dc_acc_q <= dc_acc_d; ac_q <= ac_d; fing_q <= fing_d; v1_q <= v1_d;
            t1_q <= t1_d; t2_q <= t2_d; t3_q <= t3_d; filt_q <= filt_d;
            v2_q <= v2_d; fing2_q <= fing2_d;
        end
    end

    // Stage 3: peak FSM, interval bookkeeping and divider
    state_t             state_q;
    logic signed [18:0] thr_q, pk_q, pk_half, thr_new;
    logic [7:0]         icnt_q, icnt_inc;
    logic               have_prev_q, beat_q, acc_q, in_win;
    logic               busy_q, bpm_valid_q;
    logic [3:0]         dcnt_q;
    logic [12:0]        num_q, quo_q, quo_nx;
    logic [7:0]         rem_q, den_q, rem_nx, den_start, bpm_q;
    logic [8:0]         rsh, trial;
`ifdef HR_AVG4_EN
    logic [3:0][7:0]    hist_q;
    logic [2:0]         nacc_q;
    logic [9:0]         hsum;
    assign hsum      = {2'b0, hist_q[0]} + {2'b0, hist_q[1]} + {2'b0, hist_q[2]} + {2'b0, hist_q[3]};
    assign den_start = hsum[9:2];
`else
    logic [7:0]         iv_q;
    assign den_start = iv_q;
`endif

    assign icnt_inc = (icnt_q == ICNT_SAT) ? ICNT_SAT : icnt_q + 8'd1;
    assign in_win   = have_prev_q && (icnt_inc >= 8'(MIN_INTERVAL)) && (icnt_inc <= 8'(MAX_INTERVAL));
    assign pk_half  = pk_q >>> 1;
    assign thr_new  = (pk_half > THR_MIN) ? pk_half : THR_MIN;
    assign rsh      = {rem_q, num_q[12]};
    assign trial    = rsh - {1'b0, den_q};
    assign rem_nx   = trial[8] ? rsh[7:0] : trial[7:0];
    assign quo_nx   = {quo_q[11:0], ~trial[8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NOF; thr_q <= THR_MIN; pk_q <= '0;
            icnt_q <= '0; have_prev_q <= 1'b0; beat_q <= 1'b0; acc_q <= 1'b0;
            busy_q <= 1'b0; dcnt_q <= '0; num_q <= '0; quo_q <= '0; rem_q <= '0; den_q <= '0;
            bpm_q <= '0; bpm_valid_q <= 1'b0;
`ifdef HR_AVG4_EN
            hist_q <= '0; nacc_q <= '0;
`else
            iv_q <= '0;
`endif
        end else begin
            beat_q      <= 1'b0;
            acc_q       <= 1'b0;
            bpm_valid_q <= 1'b0;
            // A new accepted interval restarts the divider, dropping any result in flight.
            if (acc_q) begin
                busy_q <= 1'b1; dcnt_q <= '0; num_q <= NUMER;
                rem_q <= '0; quo_q <= '0; den_q <= den_start;
            end else if (busy_q) begin
                num_q  <= {num_q[11:0], 1'b0};
                rem_q  <= rem_nx;
                quo_q  <= quo_nx;
                dcnt_q <= dcnt_q + 4'd1;
                if (dcnt_q == 4'd12) begin
                    busy_q      <= 1'b0;
                    bpm_q       <= (|quo_nx[12:8]) ? 8'hFF : quo_nx[7:0];
                    bpm_valid_q <= 1'b1;
                end
            end
            if (v2_q) begin
                if (!fing2_q) begin
                    state_q <= S_NOF; thr_q <= THR_MIN; pk_q <= '0;
                    icnt_q <= '0; have_prev_q <= 1'b0;
                    busy_q <= 1'b0; bpm_q <= '0; bpm_valid_q <= 1'b0;
`ifdef HR_AVG4_EN
                    hist_q <= '0; nacc_q <= '0;
`endif
                end else begin
                    icnt_q <= icnt_inc;
                    if (icnt_inc == ICNT_SAT) have_prev_q <= 1'b0;
                    case (state_q)
                        S_NOF:  state_q <= S_ARM;
                        S_ARM:  if (filt_q > thr_q) begin state_q <= S_RISE; pk_q <= filt_q; end
                        S_RISE: begin
                            if (filt_q >= pk_q) begin
                                pk_q <= filt_q;
                            end else begin
                                beat_q      <= 1'b1;
                                thr_q       <= thr_new;
                                icnt_q      <= '0;
                                have_prev_q <= 1'b1;
                                state_q     <= S_FALL;
                                if (in_win) begin
`ifdef HR_AVG4_EN
                                    hist_q <= {hist_q[2:0], icnt_inc};
                                    nacc_q <= (nacc_q == 3'd4) ? 3'd4 : nacc_q + 3'd1;
                                    acc_q  <= (nacc_q >= 3'd3);
`else
                                    iv_q  <= icnt_inc;
                                    acc_q <= 1'b1;
`endif
                                end
                            end
                        end
                        S_FALL: if (filt_q[18]) state_q <= S_ARM;
                        default: state_q <= S_NOF;
                    endcase
                end
            end
        end
    end

    assign finger_on = fing_q;
    assign beat      = beat_q;
    assign bpm       = bpm_q;
    assign bpm_valid = bpm_valid_q;
    assign ac_out    = filt_q;
endmodule

// File: tb/tb_hr_beat_detect.sv
// Directed bench for hr_beat_detect: triangle pulse waveforms, a scoreboard of
// expected BPM results keyed on observed beats, and directed edge cases.
module tb_hr_beat_detect;
    localparam int P_MIN = 30, P_MAX = 200;

    logic               clk = 1'b0, rst_n = 1'b0, dv = 1'b0;
    logic [17:0]        ir = '0;
    logic               finger_on, beat, bpm_valid;
    logic [7:0]         bpm;
    logic signed [18:0] ac_out;

    hr_beat_detect dut (
        .clk(clk), .rst_n(rst_n), .ir_data(ir), .data_valid(dv),
        .finger_on(finger_on), .beat(beat), .bpm(bpm), .bpm_valid(bpm_valid), .ac_out(ac_out)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: each accepted beat pushes the BPM it must produce and the cycle it is due.
    typedef struct { int bpm; int due; } exp_t;
    exp_t q[$];
    int   last_beat = 0, beats = 0, vcount = 0, n_push = 0, m_bpm = 0;
    int   first_valid_beats = -1;
    int   hist[4];
    int   nacc = 0;
    bit   m_have_prev = 0, fo_prev = 0;
    bit   pg_arm = 0, pg_seen = 0;
    int   pg_win = 0, pg_valids = 0;

    function automatic int sat_div(input int d);
        int r;
        r = 6000 / d;
        return (r > 255) ? 255 : r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   iv;
        if (!rst_n) begin
            q.delete(); m_have_prev = 0; nacc = 0; fo_prev = 0; m_bpm = 0;
        end else begin
            if (fo_prev && !finger_on) begin
                q.delete(); m_have_prev = 0; nacc = 0; m_bpm = 0;
            end
            fo_prev = finger_on;
            if (pg_win > 0) begin
                if (bpm_valid) pg_valids++;
                pg_win--;
            end
            if (bpm_valid) begin
                vcount++;
                if (first_valid_beats < 0) first_valid_beats = beats;
                check("pending_on_valid", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_bpm = e.bpm;
                    check("bpm_valid_cycle", cyc, e.due);
                    check("bpm_value", int'(bpm), e.bpm);
                end
            end
            if (beat) begin
                beats++;
                iv = cyc - last_beat;
                if (pg_arm) begin pg_arm = 0; pg_seen = 1; pg_win = 20; end
                if (m_have_prev && iv >= P_MIN && iv <= P_MAX) begin
`ifdef HR_AVG4_EN
                    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = iv;
                    if (nacc < 4) nacc++;
                    if (nacc == 4) begin
                        e.bpm = sat_div((hist[0] + hist[1] + hist[2] + hist[3]) >> 2);
                        e.due = cyc + 14;
                        q.push_back(e); n_push++;
                    end
`else
                    e.bpm = sat_div(iv);
                    e.due = cyc + 14;
                    q.push_back(e); n_push++;
`endif
                end
                m_have_prev = 1;
                last_beat = cyc;
            end
        end
    end

    function automatic int tri_val(input int t, input int per);
        int p, h;
        p = t % per;
        h = per / 2;
        return 99000 + ((p < h) ? (p * 2000) / h : ((per - p) * 2000) / h);
    endfunction

    task automatic drive(input int v);
        ir = 18'(v);
        dv = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tri(input int per, input int t0, input int n);
        for (int t = t0; t < t0 + n; t++) drive(tri_val(t, per));
    endtask

    task automatic flat(input int v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    initial begin
        int b0, v0, p0, tt;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        check("rst_finger_on", int'(finger_on), 0);
        check("rst_beat", int'(beat), 0);
        check("rst_bpm", int'(bpm), 0);
        check("rst_bpm_valid", int'(bpm_valid), 0);
        check("rst_ac_out", int'(ac_out), 0);
        rst_n = 1'b1;

        // 75 BPM lock
        run_tri(80, 0, 160);
        b0 = beats;
        run_tri(80, 160, 800);
        check("p80_beats_per_period", beats - b0, 10);
        check("p80_bpm", int'(bpm), 75);
`ifdef HR_AVG4_EN
        check("first_valid_after_beat", first_valid_beats, 5);
`else
        check("first_valid_after_beat", first_valid_beats, 2);
`endif

        // 300 BPM: beats but every interval is too short
        run_tri(20, 0, 60);
        b0 = beats; v0 = vcount;
        run_tri(20, 60, 340);
        check("p20_no_valid", vcount - v0, 0);
        check("p20_bpm_held", int'(bpm), m_bpm);
        check("p20_beats_present", int'((beats - b0) >= 8 && (beats - b0) <= 18), 1);

        // Relock, then flat gap and resume
        run_tri(80, 0, 480);
        check("relock_bpm", int'(bpm), 75);
        flat(100000, 50);
        v0 = vcount;
        flat(100000, 250);
        check("gap_no_valid", vcount - v0, 0);
        pg_arm = 1;
        run_tri(80, 0, 480);
        check("post_gap_beat_seen", int'(pg_seen), 1);
        check("post_gap_not_accepted", pg_valids, 0);
        check("post_gap_bpm", int'(bpm), 75);

        // Finger removed at the waveform crest, then restored
        run_tri(80, 0, 40);
        check("finger_before_drop", int'(finger_on), 1);
        drive(1000);
        check("finger_off_n1", int'(finger_on), 0);
        v0 = vcount;
        flat(1000, 30);
        check("drop_bpm_zero", int'(bpm), 0);
        check("drop_ac_zero", int'(ac_out), 0);
        check("drop_no_valid", vcount - v0, 0);
        run_tri(80, 0, 800);
        check("restore_finger", int'(finger_on), 1);
        check("restore_bpm", int'(bpm), 75);

        // 150 BPM, back-to-back samples
        run_tri(40, 0, 800);
        check("p40_bpm", int'(bpm), 150);

        // Reset five cycles after an accepting beat
        p0 = n_push; found = 0; tt = 800;
        for (int i = 0; i < 200 && !found; i++) begin
            drive(tri_val(tt, 40));
            tt++;
            @(negedge clk);
            found = (n_push != p0);
        end
        check("accepting_beat_found", int'(found), 1);
        for (int i = 0; i < 4; i++) begin
            drive(tri_val(tt, 40));
            tt++;
        end
        rst_n = 1'b0;
        dv = 1'b0;
        #1;
        check("midrst_finger_on", int'(finger_on), 0);
        check("midrst_bpm", int'(bpm), 0);
        check("midrst_bpm_valid", int'(bpm_valid), 0);
        check("midrst_ac_out", int'(ac_out), 0);
        repeat (3) @(posedge clk);
        #1;
        v0 = vcount;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("after_rst_no_valid", vcount - v0, 0);
        check("after_rst_bpm", int'(bpm), 0);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hr_beat_detect.md
# hr_beat_detect

Heart-rate extraction stage sitting directly downstream of the MAX30102 sensor driver. Consumes the 18-bit IR sample stream (`ir_data`/`data_valid`, nominally 100 Hz). It removes the DC level, smooths the pulsatile component and detects beats with an adaptive threshold. It converts beat-to-beat intervals to BPM with a sequential divider and feeds the display/UART reporting logic.

## Interface
- `SAMPLE_RATE`, default 100: sample rate in Hz; divider numerator = 60×SAMPLE_RATE (6000).
- `MIN_INTERVAL`, default 30: shortest accepted beat interval in samples (200 BPM).
- `MAX_INTERVAL`, default 200: longest accepted interval in samples (30 BPM); must be ≤ 254.
- `FINGER_TH`, default 50000: IR raw level at or above which a finger is present.
- `MIN_THR`, default 20: floor and initial value of the peak threshold (filtered AC units).
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `ir_data` in 18: IR sample, valid with `data_valid`.
- `data_valid` in 1: one-cycle strobe per sample.
- `finger_on` out 1: finger present.
- `beat` out 1: one-cycle pulse per detected peak.
- `bpm` out 8: latest heart rate, saturated at 255.
- `bpm_valid` out 1: one-cycle pulse when `bpm` updates.
- `ac_out` out 19 signed: filtered AC signal (debug/plot).

## Operation
- DC tracker: 22-bit `dc_acc` (18.4 fixed point); `dc_acc <= dc_acc + ir - dc_acc[21:4]`; dc = `dc_acc[21:4]`.
  - On the first sample after entering ARM from NO_FINGER, `dc_acc <= {ir,4'b0}`.
- AC: `ac = dc - ir`, signed 19-bit (inverted so systole is positive).
- Low-pass: 4-tap moving average, `filt = (ac0+ac1+ac2+ac3) >>> 2`, 21-bit signed sum. The taps clear on NO_FINGER entry. `ac_out = filt`.
- Interval counter `icnt` (8-bit): increments per sample and saturates at MAX_INTERVAL+1. Flag `have_prev` clears when `icnt` reaches MAX_INTERVAL+1.
- FSM, advancing only on filtered-sample strobes:
  - NO_FINGER: `finger_on`=0, threshold `thr`=MIN_THR. Moves to ARM when `ir ≥ FINGER_TH`.
  - ARM: moves to RISING when `filt > thr`; `pk <= filt`.
  - RISING: if `filt ≥ pk`, then `pk <= filt`. Otherwise a peak is declared:
    - pulse `beat`;
    - `thr <= max(pk>>>1, MIN_THR)`;
    - if `have_prev` and MIN_INTERVAL ≤ `icnt` ≤ MAX_INTERVAL, the interval is accepted;
    - `icnt <= 0`, `have_prev <= 1`;
    - go to FALLING.
  - FALLING: moves to ARM when `filt < 0`.
  - Any state: `ir < FINGER_TH` forces NO_FINGER, clears `have_prev`/`icnt`/history/averaging, and sets `bpm <= 0` with no `bpm_valid`.
- Divider: restoring, 13-bit numerator / 8-bit interval, one quotient bit per clk (13 cycles). Quotient is saturated to 255 into `bpm`.
  - An accepted interval while the divider is busy restarts it with the new value; the old result is dropped.

## Timing
- `data_valid` at cycle N → `dc`/`ac` registered N+1 → `filt` N+2 → FSM decision and `beat` at N+3.
- Accepted interval: divider starts N+4. `bpm` and `bpm_valid` update at N+17.
- `data_valid` on consecutive cycles is legal; each stage is fully pipelined.
- `finger_on` follows `ir` at N+1.
- Reset values: `finger_on`=0, `beat`=0, `bpm`=0, `bpm_valid`=0, `ac_out`=0; FSM=NO_FINGER, `thr`=MIN_THR, divider idle.
- Reset asserted mid-division aborts it; no `bpm_valid` is emitted after release.

## Configuration
- `HR_AVG4_EN` defined: the divisor is the mean of the last 4 accepted intervals (10-bit sum >> 2). No `bpm_valid` is emitted until 4 intervals have been accepted since the last NO_FINGER entry.
- `HR_AVG4_EN` undefined: the divisor is the single latest accepted interval. The first `bpm_valid` follows the second beat.

## Test plan
- DC 100000 plus a triangle of amplitude 2000 with period 80 samples. Required: `beat` once per period, `bpm`=75. First `bpm_valid` after the 2nd beat (avg off) or the 5th beat (avg on).
- Period 20 samples (300 BPM): `beat` pulses, but no `bpm_valid` is ever emitted and `bpm` holds its previous value.
- A 75 BPM run followed by a 300-sample flat signal, then resume: no `bpm` update for the gap; the first post-gap beat is not accepted (`have_prev` cleared).
- Drop `ir` to 1000 mid-run: `finger_on`=0 at N+1, `bpm`=0, no `bpm_valid`. Restore 100000: ARM and re-lock at 75.
- Period 40 samples with `data_valid` every cycle: `bpm`=150 and `bpm_valid` exactly 14 cycles after each accepting `beat` (except where a restart occurs).
- Assert `rst_n` 5 cycles after an accepting `beat`: all outputs 0, no `bpm_valid` after release.
